// File: rtl/uart_pkg.sv
// Shared UART definitions: bit-rate arithmetic, transmitter state
// encoding and parity helper, common to uart_tx and uart_rx.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } tx_state_t;

    function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

    function automatic logic parity_bit(input logic [15:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: pulses tick on the last cycle of every bit while
// enabled, reloading on each bit boundary so no drift accumulates.
module uart_baud_tick #(
    parameter int CYCLES = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [W-1:0] RELOAD = W'(CYCLES - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (!en || count == '0) begin
            count <= RELOAD;
        end else begin
            count <= count - 1'b1;
        end
    end

    assign tick = en && (count == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: serialises one byte per strobe into a framed
// line with optional parity and stop count, or sends a line break.
module uart_tx
    import uart_pkg::*;
#(
    parameter int BIT_RATE     = 9600,
    parameter int CLK_HZ       = 50000000,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int BREAK_BITS   = 11
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    uart_txd,
    output logic                    uart_tx_busy,
    input  logic                    uart_tx_en,
    input  logic [PAYLOAD_BITS-1:0] uart_tx_data,
    input  logic                    uart_tx_break
);

    localparam int CPB = cycles_per_bit(CLK_HZ, BIT_RATE);
    localparam int CNT_MAX = ((PAYLOAD_BITS > BREAK_BITS) ?
                              PAYLOAD_BITS : BREAK_BITS) + 1;
    localparam int BW = $clog2(CNT_MAX + 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(PAYLOAD_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic [BW-1:0] BRK_LOW   = BW'(BREAK_BITS);

    tx_state_t               state, state_n;
    logic [PAYLOAD_BITS-1:0] sr, sr_n;
    logic [BW-1:0]           bit_cnt, bit_cnt_n;
    logic                    par_q, par_n;
    logic                    txd_n;
    logic                    tick;

    uart_baud_tick #(
        .CYCLES(CPB)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .en   (state != IDLE),
        .tick (tick)
    );

    always_comb begin
        state_n   = state;
        sr_n      = sr;
        bit_cnt_n = bit_cnt;
        par_n     = par_q;
        txd_n     = 1'b1;
        unique case (state)
            IDLE: begin
                if (uart_tx_break) begin
                    state_n   = BREAK;
                    bit_cnt_n = '0;
                    txd_n     = 1'b0;
                end else if (uart_tx_en) begin
                    state_n = START;
                    sr_n    = uart_tx_data;
                    par_n   = parity_bit(16'(uart_tx_data), PARITY_ODD != 0);
                    txd_n   = 1'b0;
                end
            end
            START: begin
                txd_n = 1'b0;
                if (tick) begin
                    state_n   = DATA;
                    bit_cnt_n = '0;
                    txd_n     = sr[0];
                end
            end
            DATA: begin
                txd_n = sr[0];
                if (tick) begin
                    sr_n = sr >> 1;
                    if (bit_cnt == LAST_DATA) begin
                        bit_cnt_n = '0;
                        if (PARITY_EN != 0) begin
                            state_n = PARITY;
                            txd_n   = par_q;
                        end else begin
                            state_n = STOP;
                            txd_n   = 1'b1;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                        txd_n     = sr_n[0];
                    end
                end
            end
            PARITY: begin
                txd_n = par_q;
                if (tick) begin
                    state_n   = STOP;
                    bit_cnt_n = '0;
                    txd_n     = 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    if (bit_cnt == LAST_STOP) begin
                        state_n = IDLE;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
            BREAK: begin
                // low for BREAK_BITS bit times, then one mark bit
                txd_n = (bit_cnt == BRK_LOW);
                if (tick) begin
                    if (bit_cnt == BRK_LOW) begin
                        state_n = IDLE;
                        txd_n   = 1'b1;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                        txd_n     = (bit_cnt_n == BRK_LOW);
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            sr           <= '0;
            bit_cnt      <= '0;
            par_q        <= 1'b0;
            uart_txd     <= 1'b1;
            uart_tx_busy <= 1'b0;
        end else begin
            state        <= state_n;
            sr           <= sr_n;
            bit_cnt      <= bit_cnt_n;
            par_q        <= par_n;
            uart_txd     <= txd_n;
            uart_tx_busy <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame shape, latency, parity, break,
// busy-time strobes and mid-frame reset, with a loopback receiver.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data;
    logic [2:0] en, brk, txd, busy;

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [7:0] rx_q[$];
    logic       rx_break_seen;

    always #5 clk = ~clk;

    uart_tx #(
        .BIT_RATE(100000), .CLK_HZ(1000000)
    ) dut (
        .clk(clk), .reset(reset),
        .uart_txd(txd[0]), .uart_tx_busy(busy[0]),
        .uart_tx_en(en[0]), .uart_tx_data(data),
        .uart_tx_break(brk[0])
    );

    uart_tx #(
        .BIT_RATE(100000), .CLK_HZ(1000000),
        .PARITY_EN(1), .PARITY_ODD(0)
    ) dut_pe (
        .clk(clk), .reset(reset),
        .uart_txd(txd[1]), .uart_tx_busy(busy[1]),
        .uart_tx_en(en[1]), .uart_tx_data(data),
        .uart_tx_break(brk[1])
    );

    uart_tx #(
        .BIT_RATE(100000), .CLK_HZ(1000000),
        .PARITY_EN(1), .PARITY_ODD(1)
    ) dut_po (
        .clk(clk), .reset(reset),
        .uart_txd(txd[2]), .uart_tx_busy(busy[2]),
        .uart_tx_en(en[2]), .uart_tx_data(data),
        .uart_tx_break(brk[2])
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Strobe at a negedge, then check every bit time of the frame,
    // the busy duration and the first idle cycle.
    task automatic send_frame(input int sel, input logic [7:0] d,
                              input logic brk_req, input int nbits,
                              input logic [15:0] exp, input string tag);
        logic [9:0] s;
        int         nb;
        nb        = 0;
        data      = d;
        en[sel]   = 1'b1;
        brk[sel]  = brk_req;
        @(negedge clk);
        en[sel]   = 1'b0;
        brk[sel]  = 1'b0;
        check($sformatf("%s_lat", tag), {busy[sel], txd[sel]}, 2'b10);
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < 10; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                s[c] = txd[sel];
                if (busy[sel]) nb++;
            end
            check($sformatf("%s_bit%0d", tag, b), s, {10{exp[b]}});
        end
        check($sformatf("%s_busy_len", tag), nb, nbits * 10);
        @(negedge clk);
        check($sformatf("%s_idle", tag), {busy[sel], txd[sel]}, 2'b01);
    endtask

    initial begin
        rx_break_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && txd[0] === 1'b0) begin
                logic [7:0] d;
                d = '0;
                repeat (4) @(negedge clk);
                if (txd[0] === 1'b0) begin
                    for (int b = 0; b < 8; b++) begin
                        repeat (10) @(negedge clk);
                        d[b] = txd[0];
                    end
                    repeat (10) @(negedge clk);
                    if (txd[0] === 1'b1) begin
                        rx_q.push_back(d);
                    end else if (d == 8'h00) begin
                        rx_break_seen = 1'b1;
                        for (int k = 0; k < 500 && txd[0] !== 1'b1; k++)
                            @(negedge clk);
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] got;
        int         nb;
        reset = 1'b1;
        en    = '0;
        brk   = '0;
        data  = '0;
        repeat (3) @(negedge clk);
        check("rst_txd", txd, 3'b111);
        check("rst_busy", busy, 3'b000);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        send_frame(0, 8'hA5, 1'b0, 10, {1'b1, 8'hA5, 1'b0}, "t1");
        check("t1_rx_n", rx_q.size(), 1);
        got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
        check("t1_rx", got, 8'hA5);
        rx_q.delete();
        repeat (5) @(negedge clk);

        send_frame(0, 8'h00, 1'b0, 10, {1'b1, 8'h00, 1'b0}, "t2a");
        send_frame(0, 8'hFF, 1'b0, 10, {1'b1, 8'hFF, 1'b0}, "t2b");
        check("t2_rx_n", rx_q.size(), 2);
        got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
        check("t2_rx0", got, 8'h00);
        got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
        check("t2_rx1", got, 8'hFF);
        rx_q.delete();
        repeat (5) @(negedge clk);

        send_frame(1, 8'h07, 1'b0, 11, {1'b1, 1'b1, 8'h07, 1'b0}, "t3e");
        send_frame(2, 8'h07, 1'b0, 11, {1'b1, 1'b0, 8'h07, 1'b0}, "t3o");
        repeat (5) @(negedge clk);

        fork
            send_frame(0, 8'h81, 1'b0, 10, {1'b1, 8'h81, 1'b0}, "t4");
            begin
                repeat (40) @(negedge clk);
                en[0] = 1'b1;
                data  = 8'h3C;
                @(negedge clk);
                en[0] = 1'b0;
                data  = 8'hFF;
            end
        join
        nb = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy[0] !== 1'b0) nb++;
        end
        check("t4_no_requeue", nb, 0);
        check("t4_rx_n", rx_q.size(), 1);
        got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
        check("t4_rx", got, 8'h81);
        rx_q.delete();

        send_frame(0, 8'h55, 1'b1, 12, 16'h0800, "t5");
        check("t5_rx_break", rx_break_seen, 1'b1);
        check("t5_rx_n", rx_q.size(), 0);
        repeat (5) @(negedge clk);

        data  = 8'hC3;
        en[0] = 1'b1;
        @(negedge clk);
        en[0] = 1'b0;
        repeat (44) @(negedge clk);
        check("t6_pre_busy", busy[0], 1'b1);
        reset = 1'b1;
        #1;
        check("t6_rst_txd", txd[0], 1'b1);
        check("t6_rst_busy", busy[0], 1'b0);
        @(negedge clk);
        reset = 1'b0;
        repeat (150) @(negedge clk);
        rx_q.delete();
        send_frame(0, 8'h5A, 1'b0, 10, {1'b1, 8'h5A, 1'b0}, "t6");
        check("t6_rx_n", rx_q.size(), 1);
        got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
        check("t6_rx", got, 8'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter; the transmit-side counterpart of uart_rx, sharing its BIT_RATE/CLK_HZ parameterisation.
- Serialises one byte per request into an 8N1 frame (parity and stop count configurable) on uart_txd.
- Can also generate a line break.
- Sits between the fabric byte source and the board TX pin.

Parameters:
- BIT_RATE, 9600, line rate in bits/s.
- CLK_HZ, 50000000, clk frequency in Hz.
- PAYLOAD_BITS, 8, data bits per frame.
- STOP_BITS, 1, stop bits per frame (1 or 2).
- PARITY_EN, 0, 1 = append a parity bit after the data.
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity; ignored when PARITY_EN = 0.
- BREAK_BITS, 11, bit times the line is held low for a break.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- uart_txd  out  1  serial line; idle high.
- uart_tx_busy  out  1  high while a frame or break is in progress.
- uart_tx_en  in  1  single-cycle load strobe; accepted only when uart_tx_busy = 0.
- uart_tx_data  in  PAYLOAD_BITS  byte to send; sampled on the accepting edge.
- uart_tx_break  in  1  break request strobe; accepted only when uart_tx_busy = 0.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values:
  - uart_txd = 1, uart_tx_busy = 0, state = IDLE.
  - Bit counter, cycle counter and shift register = 0.
- CYCLES_PER_BIT = CLK_HZ / BIT_RATE (integer division). Cycle counter width = $clog2(CYCLES_PER_BIT).
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE:
  - uart_txd = 1, busy = 0.
  - Rising edge with uart_tx_break = 1: go to BREAK; break wins if uart_tx_en is also high.
  - Else rising edge with uart_tx_en = 1: latch uart_tx_data into the shift register and go to START.
- Latency: busy and uart_txd = 0 are both visible in the cycle after the accepting edge. Both outputs are registered.
- START: txd = 0 for exactly CYCLES_PER_BIT cycles, then DATA.
- DATA:
  - LSB first; each bit is held CYCLES_PER_BIT cycles, then the shift register shifts right.
  - After PAYLOAD_BITS bits, go to PARITY if PARITY_EN = 1, else STOP.
- PARITY:
  - Sends XOR of the latched data, XOR PARITY_ODD.
  - Parity is computed from the latched copy, not the live input.
- STOP: txd = 1 for STOP_BITS * CYCLES_PER_BIT cycles, then IDLE. busy falls in the first IDLE cycle.
- Frame length: (1 + PAYLOAD_BITS + PARITY_EN + STOP_BITS) * CYCLES_PER_BIT cycles from the first low txd cycle to the first busy = 0 cycle.
- BREAK: txd = 0 for BREAK_BITS * CYCLES_PER_BIT cycles, then 1 for one bit time (mark after break), then IDLE.
- Strobes while busy:
  - uart_tx_en and uart_tx_break are ignored; no queuing.
  - uart_tx_data changes during a frame do not affect it.
- Back-to-back: a strobe in the first IDLE cycle is accepted. Minimum inter-frame gap is 1 clk of idle-high beyond the stop bits.
- Cycle counter reloads on every bit boundary; no drift accumulates across bits.
- Reset mid-frame or mid-break: txd returns high and busy returns low asynchronously. No partial-frame completion.

Decomposition:
- Shared package uart_pkg:
  - Function cycles_per_bit(CLK_HZ, BIT_RATE).
  - Localparam-style state encoding, enum of the 6 states.
  - Parity helper function.
- uart_rx is refactored to use the same cycles_per_bit.
- Natural sub-module: uart_baud_tick, a reloadable down-counter emitting a bit-end pulse every CYCLES_PER_BIT cycles while enabled. It is reusable by uart_rx.
- Shift register and FSM stay in uart_tx.

Test Plan:
- All tests use CLK_HZ = 1000000, BIT_RATE = 100000, so 10 cycles per bit.
1. Send 0xA5, 8N1 -> txd sequence 0,1,0,1,0,0,1,0,1,1, each bit 10 cycles; busy high for exactly 100 cycles. A bench uart_rx loopback reports valid with data 0xA5.
2. Send 0x00 then 0xFF back-to-back, en in the first idle cycle -> both frames correct. Gap between frames is 1 cycle high plus the stop bit. Loopback receives 0x00 then 0xFF.
3. PARITY_EN = 1: 0x07 with even parity -> parity bit 1; with PARITY_ODD = 1 -> parity bit 0. Frame is 110 cycles.
4. Pulse uart_tx_en while busy mid-DATA with 0x3C, original byte 0x81 -> only 0x81 is transmitted, 0x3C is dropped. Changing uart_tx_data mid-frame has no effect.
5. Break and en asserted together in IDLE -> txd low for 110 cycles, high for 10, then busy = 0. The uart_rx loopback flags uart_rx_break.
6. Assert reset at cycle 45 of a frame -> txd = 1 and busy = 0 in the same cycle. A new 0x5A after reset release transmits cleanly.
